// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit check for the BCD-to-binary converter.
package bcd_pkg;

  localparam int BCD_NIBBLE_W  = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int DD_ADJ        = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  function automatic logic bcd_valid(input logic [BCD_NIBBLE_W-1:0] nibble);
    return nibble <= BCD_NIBBLE_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// start/busy/done handshake bundle between a BCD source and the converter.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (output start, bcd_in, input busy, done, err, bin_out);
  modport slave  (input start, bcd_in, output busy, done, err, bin_out);
endinterface

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble digit correction: a shifted nibble of 8 or more loses 3.
module bcd_nibble_adj
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nibble,
  output logic [BCD_NIBBLE_W-1:0] adjusted
);

  assign adjusted = (nibble >= BCD_NIBBLE_W'(8)) ? (nibble - BCD_NIBBLE_W'(DD_ADJ)) : nibble;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter, one right shift per clock.
// Invalid digits short-circuit to a one-cycle error result.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_binary_seq_if.slave bus
);

  localparam int NB    = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(NB + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [NB-1:0]      bcd_r;
  logic [NB-1:0]      bin_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic [BIN_W-1:0]   bin_out_r;

  logic [2*NB-1:0]    cat_s;
  logic [NB-1:0]      bcd_adj_s;
  logic [NB-1:0]      bin_next_s;
  logic               all_valid_s;

  assign cat_s      = {bcd_r, bin_r} >> 1;
  assign bin_next_s = cat_s[NB-1:0];

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_nibble_adj u_adj (
      .nibble   (cat_s[NB + BCD_NIBBLE_W*d +: BCD_NIBBLE_W]),
      .adjusted (bcd_adj_s[BCD_NIBBLE_W*d +: BCD_NIBBLE_W])
    );
  end

  // Whole-word digit check on the incoming operand.
  always_comb begin
    all_valid_s = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      all_valid_s = all_valid_s & bcd_valid(bus.bcd_in[BCD_NIBBLE_W*d +: BCD_NIBBLE_W]);
    end
  end

  // Control FSM, shift datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      bcd_r     <= '0;
      bin_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      bin_out_r <= '0;
    end else begin
      case (state_r)
        // DONE and ERR accept a new start exactly like IDLE, so jobs run back to back.
        S_IDLE, S_DONE, S_ERR: begin
          cnt_r <= '0;
          if (bus.start) begin
            bcd_r <= bus.bcd_in;
            bin_r <= '0;
            if (all_valid_s) begin
              state_r <= S_CONV;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
              err_r   <= 1'b0;
            end else begin
              state_r   <= S_ERR;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              err_r     <= 1'b1;
              bin_out_r <= '0;
            end
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        S_CONV: begin
          bcd_r <= bcd_adj_s;
          bin_r <= bin_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            state_r   <= S_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            err_r     <= 1'b0;
            bin_out_r <= bin_next_s[BIN_W-1:0];
          end else begin
            state_r <= S_CONV;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.bin_out = bin_out_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench: vector table, DIGITS=1 sweep, handshake corners, random vs decimal model.
module tb_bcd_to_binary_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_to_binary_seq_if #(.DIGITS(4), .BIN_W(14)) bif ();
  bcd_to_binary_seq_if #(.DIGITS(1), .BIN_W(4))  bif1 ();

  bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut  (.clk(clk), .rst(rst), .bus(bif));
  bcd_to_binary_seq #(.DIGITS(1), .BIN_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bif1));

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
    int          lat;
  } vec_t;

  vec_t        vecs [6];
  int          errors = 0;
  int          checks = 0;
  int          lat, lat1, nd, d1, d2;
  logic [13:0] bo, bo2, exp_bin;
  logic [3:0]  b1;
  logic        e, e1, bs, exp_err;
  logic [15:0] v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decimal value of the digits; any digit above nine flags an error and a zero result.
  function automatic void ref_conv(input logic [15:0] val, output logic [13:0] bin, output logic er);
    int acc;
    int w;
    int n;
    acc = 0;
    w   = 1;
    er  = 1'b0;
    for (int d = 0; d < 4; d++) begin
      n = int'(val[4*d +: 4]);
      if (n > 9) er = 1'b1;
      acc += n * w;
      w   *= 10;
    end
    bin = er ? 14'd0 : 14'(acc);
  endfunction

  task automatic convert4(input logic [15:0] val, output int l, output logic [13:0] b,
                          output logic er, output logic busy_seen);
    l = 0; b = 'x; er = 1'bx; busy_seen = 1'b0;
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bcd_in = val;
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int k = 1; k <= 40 && l == 0; k++) begin
      if (bif.busy === 1'b1) busy_seen = 1'b1;
      if (bif.done === 1'b1) begin
        l = k; b = bif.bin_out; er = bif.err;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (l != 0) begin
      @(posedge clk); #1;
      check("done_single_pulse", bif.done, 0);
      check("err_only_with_done", bif.err, 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0000, 14'd0,    1'b0, 17};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0, 17};
    vecs[2] = '{16'h0042, 14'd42,   1'b0, 17};
    vecs[3] = '{16'h1234, 14'd1234, 1'b0, 17};
    vecs[4] = '{16'h00A5, 14'd0,    1'b1, 1};
    vecs[5] = '{16'hF000, 14'd0,    1'b1, 1};

    rst = 1'b1;
    bif.start = 1'b0;  bif.bcd_in = '0;
    bif1.start = 1'b0; bif1.bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bif.busy, 0);
    check("reset_done", bif.done, 0);
    check("reset_err", bif.err, 0);
    check("reset_bin_out", bif.bin_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      convert4(vecs[i].bcd, lat, bo, e, bs);
      check("vec_latency", lat, vecs[i].lat);
      check("vec_bin_out", bo, vecs[i].bin);
      check("vec_err", e, vecs[i].err);
      check("vec_busy_seen", bs, !vecs[i].err);
    end

    for (int dv = 0; dv < 16; dv++) begin
      lat1 = 0; b1 = 'x; e1 = 1'bx;
      @(negedge clk);
      bif1.start  = 1'b1;
      bif1.bcd_in = 4'(dv);
      @(posedge clk); #1;
      bif1.start = 1'b0;
      for (int k = 1; k <= 12 && lat1 == 0; k++) begin
        if (bif1.done === 1'b1) begin
          lat1 = k; b1 = bif1.bin_out; e1 = bif1.err;
        end else begin
          @(posedge clk); #1;
        end
      end
      check("d1_bin_out", b1, (dv < 10) ? dv : 0);
      check("d1_err", e1, dv > 9);
      check("d1_latency", lat1, (dv < 10) ? 5 : 1);
    end

    // start pulses while busy must be dropped without queuing
    @(negedge clk);
    bif.start = 1'b1; bif.bcd_in = 16'h0314;
    @(posedge clk); #1;
    bif.start = 1'b0;
    nd = 0; lat = 0; bo = 'x;
    for (int k = 1; k <= 25; k++) begin
      if (k == 5 || k == 10) begin
        bif.start = 1'b1; bif.bcd_in = 16'h0999;
      end else begin
        bif.start = 1'b0;
      end
      if (bif.done === 1'b1) begin
        nd++;
        if (lat == 0) begin lat = k; bo = bif.bin_out; end
      end
      @(posedge clk); #1;
    end
    bif.start = 1'b0;
    check("busy_start_done_count", nd, 1);
    check("busy_start_latency", lat, 17);
    check("busy_start_bin_out", bo, 314);

    // start held through DONE restarts with no idle bubble
    @(negedge clk);
    bif.start = 1'b1; bif.bcd_in = 16'h0123;
    @(posedge clk); #1;
    bif.bcd_in = 16'h0007;
    d1 = 0; d2 = 0; bo = 'x; bo2 = 'x;
    for (int k = 1; k <= 45 && d2 == 0; k++) begin
      if (bif.done === 1'b1) begin
        if (d1 == 0) begin
          d1 = k; bo = bif.bin_out;
        end else begin
          d2 = k; bo2 = bif.bin_out; bif.start = 1'b0;
        end
      end
      if (d2 == 0) begin
        @(posedge clk); #1;
        if (k == d1 && d1 != 0) check("restart_busy_after_done", bif.busy, 1);
      end
    end
    bif.start = 1'b0;
    check("restart_first_cycle", d1, 17);
    check("restart_first_bin", bo, 123);
    check("restart_second_cycle", d2, 34);
    check("restart_second_bin", bo2, 7);
    @(posedge clk); #1;
    check("restart_no_third", bif.busy, 0);

    // synchronous reset in the middle of a conversion
    @(negedge clk);
    bif.start = 1'b1; bif.bcd_in = 16'h5678;
    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", bif.busy, 0);
    check("midrst_done", bif.done, 0);
    check("midrst_err", bif.err, 0);
    check("midrst_bin_out", bif.bin_out, 0);
    rst = 1'b0;
    nd = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1) nd++;
    end
    check("midrst_no_done", nd, 0);
    convert4(16'h0815, lat, bo, e, bs);
    check("midrst_fresh_bin", bo, 815);
    check("midrst_fresh_latency", lat, 17);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = 16'($urandom);
      end else begin
        for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      ref_conv(v, exp_bin, exp_err);
      convert4(v, lat, bo, e, bs);
      check("rand_bin_out", bo, exp_bin);
      check("rand_err", e, exp_err);
      check("rand_latency", lat, exp_err ? 1 : 17);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
